// File: rtl/modulo_controlador_vedacao.sv
// Bottle capping line controller: conveyor/capper sequencing with a cork magazine
// counter that saturates on reload and a wrapping count of capped bottles.
module modulo_controlador_vedacao #(
  parameter int unsigned VEDA_CICLOS = 4,
  parameter int unsigned RECARGA     = 15,
  parameter int unsigned MAX_ROLHAS  = 100
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       iniciar,
  input  logic       sensor_garrafa,
  input  logic       recarga,
  output logic       motor_esteira,
  output logic       vedador,
  output logic [6:0] reg_r,
  output logic       aus_rolhas,
  output logic [7:0] garrafas_vedadas
);

  typedef enum logic [2:0] {
    StParado,
    StTransporte,
    StVedando,
    StLibera,
    StSemRolha
  } estado_e;

  localparam logic [3:0] TimerCarga = 4'(VEDA_CICLOS - 1);
  localparam logic [7:0] Recarga8   = 8'(RECARGA);
  localparam logic [7:0] Max8       = 8'(MAX_ROLHAS);

  estado_e    state_q, state_d;
  logic [3:0] timer_q, timer_d;
  logic       decrementa;
  logic [7:0] soma;
  logic [6:0] rolhas_d;
  logic [7:0] garrafas_d;

  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    decrementa    = 1'b0;
    motor_esteira = 1'b0;
    vedador       = 1'b0;
    case (state_q)
      StParado: begin
        if (iniciar) state_d = StTransporte;
      end
      StTransporte: begin
        motor_esteira = 1'b1;
        if (!iniciar) begin
          state_d = StParado;
        end else if (sensor_garrafa && (reg_r != '0)) begin
          state_d = StVedando;
          timer_d = TimerCarga;
        end else if (sensor_garrafa) begin
          state_d = StSemRolha;
        end
      end
      StVedando: begin
        // Inputs deliberately ignored: a started capping always completes.
        vedador = 1'b1;
        if (timer_q == '0) begin
          decrementa = 1'b1;
          state_d    = StLibera;
        end else begin
          timer_d = timer_q - 4'd1;
        end
      end
      StLibera: begin
        motor_esteira = 1'b1;
        if (!sensor_garrafa) state_d = iniciar ? StTransporte : StParado;
      end
      StSemRolha: begin
        if (!iniciar) begin
          state_d = StParado;
        end else if (reg_r != '0) begin
          state_d = StVedando;
          timer_d = TimerCarga;
        end
      end
      default: state_d = StParado;
    endcase
  end

  // 8-bit sum so reload plus a full magazine cannot wrap before saturation.
  always_comb begin
    soma       = {1'b0, reg_r} + (recarga ? Recarga8 : 8'd0) - {7'd0, decrementa};
    rolhas_d   = (soma > Max8) ? Max8[6:0] : soma[6:0];
    garrafas_d = garrafas_vedadas + {7'd0, decrementa};
  end

  assign aus_rolhas = (reg_r == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= StParado;
      timer_q          <= '0;
      reg_r            <= '0;
      garrafas_vedadas <= '0;
    end else begin
      state_q          <= state_d;
      timer_q          <= timer_d;
      reg_r            <= rolhas_d;
      garrafas_vedadas <= garrafas_d;
    end
  end

endmodule

// File: tb/tb_modulo_controlador_vedacao.sv
// Self-checking bench: vector table, directed corner sequences and randomized
// stimulus against a cycle-level model of the capping line.
module tb_modulo_controlador_vedacao;

  localparam int VEDA = 4;
  localparam int REC  = 15;
  localparam int MAXR = 100;

  localparam int M_IDLE = 0, M_RUN = 1, M_CAP = 2, M_REL = 3, M_STARVE = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       iniciar = 1'b0, sensor_garrafa = 1'b0, recarga = 1'b0;
  logic       motor_esteira, vedador, aus_rolhas;
  logic [6:0] reg_r;
  logic [7:0] garrafas_vedadas;

  int n_checks = 0;
  int n_fail   = 0;

  int m_mode, m_left, m_stock, m_cnt;

  typedef struct {
    logic ini, sen, rec;
    logic m, v;
    int   r, g;
  } vec_t;
  vec_t tab [9];

  modulo_controlador_vedacao #(
    .VEDA_CICLOS(VEDA),
    .RECARGA    (REC),
    .MAX_ROLHAS (MAXR)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .iniciar         (iniciar),
    .sensor_garrafa  (sensor_garrafa),
    .recarga         (recarga),
    .motor_esteira   (motor_esteira),
    .vedador         (vedador),
    .reg_r           (reg_r),
    .aus_rolhas      (aus_rolhas),
    .garrafas_vedadas(garrafas_vedadas)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic em, input logic ev, input int er,
                       input int eg);
    logic [17:0] act, exp_v;
    logic [6:0]  er7;
    logic [7:0]  eg8;
    er7   = er[6:0];
    eg8   = eg[7:0];
    act   = {motor_esteira, vedador, aus_rolhas, reg_r, garrafas_vedadas};
    exp_v = {em, ev, (er == 0), er7, eg8};
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s @%0t: got m=%0b v=%0b aus=%0b r=%0d g=%0d, expected m=%0b v=%0b aus=%0b r=%0d g=%0d",
               name, $time, motor_esteira, vedador, aus_rolhas, reg_r, garrafas_vedadas,
               em, ev, (er == 0), er, eg);
    end
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    iniciar = 1'b0; sensor_garrafa = 1'b0; recarga = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step;
    check("reset", 1'b0, 1'b0, 0, 0);
    m_mode = M_IDLE; m_left = 0; m_stock = 0; m_cnt = 0;
  endtask

  // Next state of the line as described by the operating rules.
  task automatic model_step(input logic ini, input logic sen, input logic rec);
    int ns;
    ns = m_stock + (rec ? REC : 0) - ((m_mode == M_CAP && m_left == 1) ? 1 : 0);
    if (ns > MAXR) ns = MAXR;
    case (m_mode)
      M_IDLE: if (ini) m_mode = M_RUN;
      M_RUN: begin
        if (!ini) m_mode = M_IDLE;
        else if (sen && m_stock > 0) begin m_mode = M_CAP; m_left = VEDA; end
        else if (sen) m_mode = M_STARVE;
      end
      M_CAP: begin
        if (m_left == 1) begin m_mode = M_REL; m_cnt = (m_cnt + 1) % 256; end
        else m_left--;
      end
      M_REL: if (!sen) m_mode = ini ? M_RUN : M_IDLE;
      default: begin
        if (!ini) m_mode = M_IDLE;
        else if (m_stock > 0) begin m_mode = M_CAP; m_left = VEDA; end
      end
    endcase
    m_stock = ns;
  endtask

  // From conveyor running with no bottle: caps one bottle and returns to conveying.
  task automatic cap_bottle(input bit rec_last, input int r0, input int g0, output int r1,
                            output int g1);
    sensor_garrafa = 1'b1;
    step;
    check("cap_enter", 1'b0, 1'b1, r0, g0);
    for (int i = 1; i < VEDA; i++) begin
      step;
      check("cap_hold", 1'b0, 1'b1, r0, g0);
    end
    recarga = rec_last;
    step;
    recarga = 1'b0;
    r1 = r0 - 1 + (rec_last ? REC : 0);
    if (r1 > MAXR) r1 = MAXR;
    g1 = (g0 + 1) % 256;
    check("cap_done", 1'b1, 1'b0, r1, g1);
    sensor_garrafa = 1'b0;
    step;
    check("cap_release", 1'b1, 1'b0, r1, g1);
  endtask

  initial begin
    int r, g;
    tab[0] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 15, 0};
    tab[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 15, 0};
    tab[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 15, 0};
    tab[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 15, 0};
    tab[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 15, 0};
    tab[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 15, 0};
    tab[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 14, 1};
    tab[7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 14, 1};
    tab[8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 14, 1};

    // Normal cap
    do_reset;
    for (int i = 0; i < 9; i++) begin
      iniciar = tab[i].ini; sensor_garrafa = tab[i].sen; recarga = tab[i].rec;
      step;
      check($sformatf("table%0d", i), tab[i].m, tab[i].v, tab[i].r, tab[i].g);
    end

    // Empty magazine
    do_reset;
    iniciar = 1'b1; sensor_garrafa = 1'b1;
    step;
    check("empty_transp", 1'b1, 1'b0, 0, 0);
    step;
    check("empty_semrolha", 1'b0, 1'b0, 0, 0);
    recarga = 1'b1;
    step;
    recarga = 1'b0;
    check("empty_reload", 1'b0, 1'b0, 15, 0);
    step;
    check("empty_vedando", 1'b0, 1'b1, 15, 0);

    // Saturation
    do_reset;
    recarga = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step;
      check($sformatf("sat%0d", k), 1'b0, 1'b0, (REC * k > MAXR) ? MAXR : REC * k, 0);
    end
    recarga = 1'b0;

    // Reload on the final capping cycle, reg_r = 90
    do_reset;
    recarga = 1'b1;
    repeat (6) step;
    recarga = 1'b0;
    iniciar = 1'b1;
    step;
    check("pre90", 1'b1, 1'b0, 90, 0);
    cap_bottle(1'b1, 90, 0, r, g);

    // Drain to 1 cork, then reload on the final cycle
    do_reset;
    recarga = 1'b1;
    step;
    recarga = 1'b0;
    iniciar = 1'b1;
    step;
    r = 15; g = 0;
    for (int k = 0; k < 14; k++) cap_bottle(1'b0, r, g, r, g);
    check("drained", 1'b1, 1'b0, 1, 14);
    cap_bottle(1'b1, r, g, r, g);
    // Keep capping with reloads until the bottle count wraps past 255
    for (int k = 0; k < 245; k++) cap_bottle(1'b1, r, g, r, g);

    // Stop during capping
    do_reset;
    recarga = 1'b1;
    step;
    recarga = 1'b0;
    iniciar = 1'b1;
    step;
    sensor_garrafa = 1'b1;
    step;
    check("stop_c1", 1'b0, 1'b1, 15, 0);
    iniciar = 1'b0;
    for (int i = 2; i <= VEDA; i++) begin
      step;
      check("stop_hold", 1'b0, 1'b1, 15, 0);
    end
    step;
    check("stop_libera", 1'b1, 1'b0, 14, 1);
    step;
    check("stop_libera_hold", 1'b1, 1'b0, 14, 1);
    sensor_garrafa = 1'b0;
    step;
    check("stop_parado", 1'b0, 1'b0, 14, 1);

    // Reset in the middle of capping
    do_reset;
    recarga = 1'b1;
    step;
    recarga = 1'b0;
    iniciar = 1'b1;
    step;
    sensor_garrafa = 1'b1;
    repeat (3) step;
    check("mid_c3", 1'b0, 1'b1, 15, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", 1'b0, 1'b0, 0, 0);
    iniciar = 1'b0; sensor_garrafa = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step;
    check("post_reset_idle", 1'b0, 1'b0, 0, 0);
    iniciar = 1'b1;
    step;
    check("post_reset_run", 1'b1, 1'b0, 0, 0);

    // Randomized against the model
    do_reset;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 499) == 0) do_reset;
      iniciar = ($urandom_range(0, 19) != 0);
      if ($urandom_range(0, 3) == 0) sensor_garrafa = ~sensor_garrafa;
      recarga = ($urandom_range(0, 9) == 0);
      model_step(iniciar, sensor_garrafa, recarga);
      step;
      check("random", (m_mode == M_RUN) || (m_mode == M_REL), (m_mode == M_CAP), m_stock,
            m_cnt);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
